// File: rtl/pq_req_arb.sv
// Round-robin arbiter sharing one priority queue among N_REQ requesters.
// One PQ operation at a time, with a forced idle gap and routed dequeue responses.
package pq_pkg;
    parameter int KEY_WIDTH = 8;
    parameter int VAL_WIDTH = 8;
endpackage

module pq_req_arb #(
    parameter int N_REQ     = 4,
    parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
    parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
    parameter int ISSUE_GAP = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_REQ-1:0]                      req_enq,
    input  logic [N_REQ-1:0]                      req_deq,
    input  logic [N_REQ*(KEY_WIDTH+VAL_WIDTH)-1:0] req_kv,
    output logic [N_REQ-1:0]                      req_ack,
    output logic [N_REQ-1:0]                      rsp_valid,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0]        rsp_kv,
    output logic                                  rsp_err,
    output logic                                  pq_enq,
    output logic                                  pq_deq,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0]        pq_kvi,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0]        pq_kvo,
    input  logic                                  pq_full,
    input  logic                                  pq_empty
);

    localparam int KV_W = KEY_WIDTH + VAL_WIDTH;
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     gnt_q, gnt_d;
    logic              enq_q, enq_d;
    logic              deq_q, deq_d;
    logic [KV_W-1:0]   kv_q, kv_d;
    logic [3:0]        gap_q, gap_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [KV_W-1:0]   rsp_kv_q, rsp_kv_d;
    logic              rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0]  elig;
    logic              found;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     rr_nxt;
    int                idx;

    // Enq-only requests wait while the PQ is full; anything with a deq may go.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = (req_enq[i] | req_deq[i])
                    & ~(req_enq[i] & ~req_deq[i] & pq_full);
        end
    end

    // First eligible requester at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    assign rr_nxt = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;

    // Next-state, PQ strobes, acks and response capture.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        enq_d       = enq_q;
        deq_d       = deq_q;
        kv_d        = kv_q;
        gap_d       = gap_q;
        rsp_valid_d = '0;
        rsp_kv_d    = rsp_kv_q;
        rsp_err_d   = rsp_err_q;
        req_ack     = '0;
        pq_enq      = 1'b0;
        pq_deq      = 1'b0;
        pq_kvi      = '0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = pick;
                    enq_d   = req_enq[pick];
                    deq_d   = req_deq[pick];
                    kv_d    = req_kv[int'(pick)*KV_W +: KV_W];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pq_kvi         = kv_q;
                req_ack[gnt_q] = 1'b1;
                if (deq_q) begin
                    pq_enq             = enq_q;
                    pq_deq             = ~pq_empty;
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_kv_d           = pq_empty ? '0 : pq_kvo;
                    rsp_err_d          = pq_empty;
                end else begin
                    pq_enq = 1'b1;
                end
                rr_d = rr_nxt;
                if (ISSUE_GAP > 0) begin
                    gap_d   = 4'(ISSUE_GAP - 1);
                    state_d = S_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and response registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            gnt_q       <= '0;
            enq_q       <= 1'b0;
            deq_q       <= 1'b0;
            kv_q        <= '0;
            gap_q       <= '0;
            rsp_valid_q <= '0;
            rsp_kv_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            enq_q       <= enq_d;
            deq_q       <= deq_d;
            kv_q        <= kv_d;
            gap_q       <= gap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_kv_q    <= rsp_kv_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_kv    = rsp_kv_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_pq_req_arb.sv
// Scoreboard bench for pq_req_arb: directed requests, expected acks and
// responses queued by the stimulus and checked by an independent monitor.
module tb_pq_req_arb;

    typedef struct packed {
        logic [3:0]  ack;
        logic        enq;
        logic        deq;
        logic [15:0] kvi;
    } ack_t;

    typedef struct packed {
        logic [3:0]  vld;
        logic [15:0] kv;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req_enq;
    logic [3:0]  req_deq;
    logic [63:0] req_kv;
    logic [3:0]  req_ack;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_kv;
    logic        rsp_err;
    logic        pq_enq;
    logic        pq_deq;
    logic [15:0] pq_kvi;
    logic [15:0] pq_kvo;
    logic        pq_full;
    logic        pq_empty;

    ack_t ackq[$];
    rsp_t rspq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   ack_cyc[4];
    int   t0;

    pq_req_arb #(
        .N_REQ(4),
        .KEY_WIDTH(8),
        .VAL_WIDTH(8),
        .ISSUE_GAP(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_enq(req_enq),
        .req_deq(req_deq),
        .req_kv(req_kv),
        .req_ack(req_ack),
        .rsp_valid(rsp_valid),
        .rsp_kv(rsp_kv),
        .rsp_err(rsp_err),
        .pq_enq(pq_enq),
        .pq_deq(pq_deq),
        .pq_kvi(pq_kvi),
        .pq_kvo(pq_kvo),
        .pq_full(pq_full),
        .pq_empty(pq_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ack(input logic [3:0] a, input logic e,
                            input logic d, input logic [15:0] kv);
        ack_t x;
        x.ack = a;
        x.enq = e;
        x.deq = d;
        x.kvi = kv;
        ackq.push_back(x);
    endtask

    task automatic push_rsp(input logic [3:0] v, input logic [15:0] kv,
                            input logic err);
        rsp_t x;
        x.vld = v;
        x.kv  = kv;
        x.err = err;
        rspq.push_back(x);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((ackq.size() != 0 || rspq.size() != 0) && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk(name, (n < 60), 1);
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT acks or responds.
    initial begin
        ack_t ea;
        rsp_t er;
        int   gi;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if ((pq_enq || pq_deq) && req_ack == 4'b0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pq_strobe_no_ack: enq %0b deq %0b", pq_enq, pq_deq);
                end
                if (req_ack != 4'b0) begin
                    for (int i = 0; i < 4; i++) begin
                        if (req_ack[i]) ack_cyc[i] = cyc;
                    end
                    if (ackq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_ack: got %0h expected none", req_ack);
                    end else begin
                        ea = ackq.pop_front();
                        chk("ack", {req_ack, pq_enq, pq_deq, pq_kvi}, ea);
                    end
                end
                if (rsp_valid != 4'b0) begin
                    gi = 0;
                    for (int i = 0; i < 4; i++) begin
                        if (rsp_valid[i]) gi = i;
                    end
                    chk("rsp_lat", cyc - ack_cyc[gi], 1);
                    if (rspq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got %0h expected none", rsp_valid);
                    end else begin
                        er = rspq.pop_front();
                        chk("rsp", {rsp_valid, rsp_kv, rsp_err}, er);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        req_enq  = '0;
        req_deq  = '0;
        req_kv   = '0;
        pq_kvo   = '0;
        pq_full  = 1'b0;
        pq_empty = 1'b1;
        for (int i = 0; i < 4; i++) ack_cyc[i] = 0;

        fork
            begin : dropper
                logic [3:0] a;
                forever begin
                    @(negedge clk);
                    a = req_ack;
                    @(posedge clk);
                    #1;
                    req_enq = req_enq & ~a;
                    req_deq = req_deq & ~a;
                end
            end
        join_none

        repeat (2) @(negedge clk);
        chk("rst_ack", req_ack, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_kv", rsp_kv, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_pq_enq", pq_enq, 0);
        chk("rst_pq_deq", pq_deq, 0);
        chk("rst_pq_kvi", pq_kvi, 0);
        rst = 1'b0;

        // 1: single enqueue from requester 0
        @(posedge clk);
        #2;
        req_kv[0*16 +: 16] = 16'h080E;
        push_ack(4'b0001, 1'b1, 1'b0, 16'h080E);
        req_enq[0] = 1'b1;
        t0 = cyc;
        drain("t1_drain");
        chk("t1_lat", ack_cyc[0] - t0, 1);

        // 2: dequeue from requester 2, head is {2,12}
        pq_empty = 1'b0;
        pq_kvo   = 16'h020C;
        @(posedge clk);
        #2;
        req_kv[2*16 +: 16] = 16'h0707;
        push_ack(4'b0100, 1'b0, 1'b1, 16'h0707);
        push_rsp(4'b0100, 16'h020C, 1'b0);
        req_deq[2] = 1'b1;
        t0 = cyc;
        drain("t2_drain");
        chk("t2_lat", ack_cyc[2] - t0, 1);

        // 3: all four enqueue, pointer at 0 after reset
        do_reset();
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            req_kv[i*16 +: 16] = 16'h0900 | 16'(i);
            push_ack(4'(1 << i), 1'b1, 1'b0, 16'h0900 | 16'(i));
        end
        req_enq = 4'hF;
        drain("t3a_drain");
        chk("t3a_sp01", ack_cyc[1] - ack_cyc[0], 3);
        chk("t3a_sp12", ack_cyc[2] - ack_cyc[1], 3);
        chk("t3a_sp23", ack_cyc[3] - ack_cyc[2], 3);

        // move pointer to 2 with a lone grant to requester 1
        @(posedge clk);
        #2;
        req_kv[1*16 +: 16] = 16'h0501;
        push_ack(4'b0010, 1'b1, 1'b0, 16'h0501);
        req_enq[1] = 1'b1;
        drain("t3b_prep");

        @(posedge clk);
        #2;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (k + 2) % 4;
            req_kv[i*16 +: 16] = 16'h0900 | 16'(i);
            push_ack(4'(1 << i), 1'b1, 1'b0, 16'h0900 | 16'(i));
        end
        req_enq = 4'hF;
        drain("t3b_drain");
        chk("t3b_sp23", ack_cyc[3] - ack_cyc[2], 3);
        chk("t3b_sp30", ack_cyc[0] - ack_cyc[3], 3);
        chk("t3b_sp01", ack_cyc[1] - ack_cyc[0], 3);

        // 4: PQ full, enq-only blocked, enq+deq goes through
        pq_full  = 1'b1;
        pq_empty = 1'b0;
        pq_kvo   = 16'h020C;
        @(posedge clk);
        #2;
        req_kv[1*16 +: 16] = 16'h0C0C;
        req_kv[3*16 +: 16] = 16'h010B;
        push_ack(4'b1000, 1'b1, 1'b1, 16'h010B);
        push_rsp(4'b1000, 16'h020C, 1'b0);
        req_enq[1] = 1'b1;
        req_enq[3] = 1'b1;
        req_deq[3] = 1'b1;
        drain("t4a_drain");
        repeat (6) @(posedge clk);
        chk("t4_hold_req1", req_enq[1], 1);
        @(posedge clk);
        #2;
        push_ack(4'b0010, 1'b1, 1'b0, 16'h0C0C);
        pq_full = 1'b0;
        t0 = cyc;
        drain("t4b_drain");
        chk("t4_lat_after_full", ack_cyc[1] - t0, 1);

        // 5: dequeue on empty PQ
        pq_empty = 1'b1;
        pq_kvo   = 16'h0F0F;
        @(posedge clk);
        #2;
        req_kv[0*16 +: 16] = 16'h0A0A;
        push_ack(4'b0001, 1'b0, 1'b0, 16'h0A0A);
        push_rsp(4'b0001, 16'h0000, 1'b1);
        req_deq[0] = 1'b1;
        drain("t5_drain");

        // 6: reset while the grant is in ISSUE
        pq_empty = 1'b0;
        pq_kvo   = 16'h0305;
        @(posedge clk);
        #2;
        req_kv[1*16 +: 16] = 16'h0404;
        req_deq[1] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_ack", req_ack, 0);
        chk("t6_pq_enq", pq_enq, 0);
        chk("t6_pq_deq", pq_deq, 0);
        chk("t6_pq_kvi", pq_kvi, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge clk);
        chk("t6_rsp_kv", rsp_kv, 0);
        chk("t6_req_held", req_deq[1], 1);
        push_ack(4'b0010, 1'b0, 1'b1, 16'h0404);
        push_rsp(4'b0010, 16'h0305, 1'b0);
        rst = 1'b0;
        drain("t6_drain");

        chk("ackq_empty", ackq.size(), 0);
        chk("rspq_empty", rspq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
